score_glyph_renderer: RTL and testbench

SCORE_GLYPH_RENDERER -- requirements
Module: score_glyph_renderer

---
 rtl/score_glyph_renderer.sv | 133 +++++++++++++
 tb/tb_score_glyph_renderer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/score_glyph_renderer.sv
// score_glyph_renderer: 2-stage 10x10 seven-segment digit pixel renderer with optional score flash.
// Define SCORE_FLASH_EN to build the score-event flash FSM; otherwise glyphs are always drawn in FG_COLOR.
module score_glyph_renderer #(
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] FLASH_COLOR  = 12'hFF0,
    parameter int          FLASH_FRAMES = 8,
    parameter int          FLASH_PHASES = 6
) (
    input  logic        clock_25,
    input  logic        reset,
    input  logic        sync_reset,
    input  logic        en_score,
    input  logic [3:0]  selected_score_number,
    input  logic [7:0]  score_count,
    input  logic [6:0]  score,
    input  logic        frame_start,
    output logic        pixel_valid,
    output logic        pixel_on,
    output logic [11:0] pixel_rgb
);
    logic       en1;
    logic [3:0] num1;
    logic [4:0] row1;
    logic [3:0] col1;
    logic [6:0] segs;
    logic       horiz, upper, lower, glyph, lit;
    logic       flash_on, flash_off;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            en1  <= 1'b0;
            num1 <= '0;
            row1 <= '0;
            col1 <= '0;
            pixel_valid <= 1'b0;
            pixel_on    <= 1'b0;
            pixel_rgb   <= '0;
        end else if (sync_reset) begin
            en1  <= 1'b0;
            num1 <= '0;
            row1 <= '0;
            col1 <= '0;
            pixel_valid <= 1'b0;
            pixel_on    <= 1'b0;
            pixel_rgb   <= '0;
        end else begin
            en1  <= en_score;
            num1 <= selected_score_number;
            row1 <= 5'(score_count / 8'd10);
            col1 <= 4'(score_count % 8'd10);
            pixel_valid <= en1;
            pixel_on    <= lit;
            pixel_rgb   <= lit ? (flash_on ? FLASH_COLOR : FG_COLOR) : 12'h000;
        end
    end

    // Segment bits are {g,f,e,d,c,b,a}; out-of-range digits light nothing.
    always_comb begin
        segs = 7'h00;
        case (num1)
            4'd0: segs = 7'h3F;
            4'd1: segs = 7'h06;
            4'd2: segs = 7'h5B;
            4'd3: segs = 7'h4F;
            4'd4: segs = 7'h66;
            4'd5: segs = 7'h6D;
            4'd6: segs = 7'h7D;
            4'd7: segs = 7'h07;
            4'd8: segs = 7'h7F;
            4'd9: segs = 7'h6F;
            default: segs = 7'h00;
        endcase
    end

    // Rows past 9 (addresses above 99) fall outside every stroke.
    assign horiz = (col1 >= 4'd1) && (col1 <= 4'd8);
    assign upper = (row1 >= 5'd1) && (row1 <= 5'd3);
    assign lower = (row1 >= 5'd5) && (row1 <= 5'd8);
    assign glyph = (segs[0] && row1 == 5'd0 && horiz)
                 | (segs[6] && row1 == 5'd4 && horiz)
                 | (segs[3] && row1 == 5'd9 && horiz)
                 | (segs[1] && col1 == 4'd9 && upper)
                 | (segs[2] && col1 == 4'd9 && lower)
                 | (segs[4] && col1 == 4'd0 && lower)
                 | (segs[5] && col1 == 4'd0 && upper);
    assign lit = glyph && en1 && !flash_off;

`ifdef SCORE_FLASH_EN
    typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} state_t;
    state_t     state;
    logic [7:0] frame_cnt;
    logic [3:0] phase_cnt;
    logic [6:0] score_prev;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            phase_cnt  <= '0;
            score_prev <= '0;
        end else if (sync_reset) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            phase_cnt  <= '0;
            score_prev <= '0;
        end else begin
            score_prev <= score;
            if (score > score_prev) begin
                state     <= FLASH_ON;
                frame_cnt <= '0;
                phase_cnt <= '0;
            end else if (frame_start && state != IDLE) begin
                if (frame_cnt == 8'(FLASH_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    phase_cnt <= phase_cnt + 4'd1;
                    state     <= (phase_cnt == 4'(FLASH_PHASES - 1)) ? IDLE :
                                 (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    assign flash_on  = (state == FLASH_ON);
    assign flash_off = (state == FLASH_OFF);
`else
    logic unused_flash;
    assign unused_flash = ^{score, frame_start};
    assign flash_on  = 1'b0;
    assign flash_off = 1'b0;
`endif
endmodule

// File: tb/tb_score_glyph_renderer.sv
// tb_score_glyph_renderer: directed plus randomized checks of the glyph renderer against a bitmap model.
module tb_score_glyph_renderer;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] FL = 12'hFF0;

    logic        clock_25 = 1'b0;
    logic        reset = 1'b0;
    logic        sync_reset = 1'b0;
    logic        en_score = 1'b0;
    logic [3:0]  selected_score_number = '0;
    logic [7:0]  score_count = '0;
    logic [6:0]  score = '0;
    logic        frame_start = 1'b0;
    logic        pixel_valid, pixel_on;
    logic [11:0] pixel_rgb;

    int checks = 0;
    int errors = 0;
    bit bm [0:9][0:99];
    string segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    logic [13:0] pa = '0, pb = '0;
    bit pipe_chk = 1'b1;
    bit rand_side = 1'b0;

    score_glyph_renderer dut (
        .clock_25(clock_25), .reset(reset), .sync_reset(sync_reset), .en_score(en_score),
        .selected_score_number(selected_score_number), .score_count(score_count),
        .score(score), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .pixel_on(pixel_on), .pixel_rgb(pixel_rgb)
    );

    always #20 clock_25 = ~clock_25;

    function automatic logic [13:0] model(input logic en, input logic [3:0] num, input logic [7:0] cnt);
        logic on;
        on = en && num < 4'd10 && cnt < 8'd100 && bm[num][cnt];
        return {en, on, on ? FG : 12'h000};
    endfunction

    // Flash sequence seen after f frame pulses following a score event.
    function automatic logic [13:0] flash_exp(input int f);
        int  ph;
        bit  idle, on;
        ph   = f / 8;
        idle = ph >= 6;
        on   = idle || (ph % 2 == 0);
        return {1'b1, on, on ? (idle ? FG : FL) : 12'h000};
    endfunction

    task automatic chk(input string tag, input logic [13:0] exp);
        checks++;
        assert ({pixel_valid, pixel_on, pixel_rgb} === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, {pixel_valid, pixel_on, pixel_rgb}, exp);
        end
    endtask

    task automatic step(input logic en, input logic [3:0] num, input logic [7:0] cnt, input logic sr);
        @(negedge clock_25);
        if (pipe_chk) chk("pixel", pb);
        pb = sr ? '0 : pa;
        pa = sr ? '0 : model(en, num, cnt);
        en_score = en;
        selected_score_number = num;
        score_count = cnt;
        sync_reset = sr;
        if (rand_side) begin
            score = 7'($urandom);
            frame_start = 1'($urandom);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_25);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            @(negedge clock_25);
            frame_start = 1'b0;
        end
        cyc(3);
    endtask

    initial begin
        for (int d = 0; d < 10; d++)
            for (int k = 0; k < segs[d].len(); k++)
                for (int i = 0; i < 10; i++)
                    case (segs[d][k])
                        "a": if (i >= 1 && i <= 8) bm[d][i] = 1'b1;
                        "g": if (i >= 1 && i <= 8) bm[d][40 + i] = 1'b1;
                        "d": if (i >= 1 && i <= 8) bm[d][90 + i] = 1'b1;
                        "b": if (i >= 1 && i <= 3) bm[d][i * 10 + 9] = 1'b1;
                        "c": if (i >= 5 && i <= 8) bm[d][i * 10 + 9] = 1'b1;
                        "f": if (i >= 1 && i <= 3) bm[d][i * 10] = 1'b1;
                        "e": if (i >= 5 && i <= 8) bm[d][i * 10] = 1'b1;
                        default: ;
                    endcase
`ifndef SCORE_FLASH_EN
        rand_side = 1'b1;
`endif
        #5 reset = 1'b1;
        #1 chk("reset", 14'h0);
        cyc(2);
        reset = 1'b0;

        step(1, 1, 19, 0);
        step(1, 1, 44, 0);
        step(1, 8, 0, 0);
        step(1, 8, 45, 0);
        step(1, 12, 45, 0);
        step(1, 8, 100, 0);
        step(0, 8, 45, 0);
        step(1, 0, 1, 0);
        step(1, 7, 255, 0);
        step(1, 2, 99, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        @(negedge clock_25);
        chk("req34", 14'h0);
        selected_score_number = 4'd1;
        score_count = 8'd19;
        en_score = 1'b1;
        @(negedge clock_25);
        en_score = 1'b0;
        @(negedge clock_25);
        chk("req34_n2", {2'b11, FG});
        pa = '0;
        pb = '0;

        step(1, 8, 45, 0);
        step(1, 8, 45, 1);
        step(0, 0, 0, 0);
        step(1, 8, 45, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        for (int n = 0; n < 300; n++)
            step(($urandom % 4) != 0, 4'($urandom_range(0, 11)),
                 ($urandom % 8 == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 99)), 0);

        step(1, 8, 45, 0);
        step(1, 8, 45, 0);
        #5 reset = 1'b1;
        #1 chk("async_reset", 14'h0);
        en_score = 1'b0;
        score = '0;
        frame_start = 1'b0;
        pa = '0;
        pb = '0;
        @(negedge clock_25);
        reset = 1'b0;
        step(1, 1, 19, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

`ifdef SCORE_FLASH_EN
        pipe_chk = 1'b0;
        en_score = 1'b1;
        selected_score_number = 4'd0;
        score_count = 8'd1;
        score = 7'd5;
        cyc(2);
        score = 7'd6;
        cyc(3);
        for (int f = 0; f <= 48; f++) begin
            chk($sformatf("flash_f%0d", f), flash_exp(f));
            if (f < 48) pulses(1);
        end
        score = 7'd5;
        cyc(3);
        chk("score_drop", {2'b11, FG});
        score = 7'd6;
        cyc(3);
        chk("reflash_on", flash_exp(0));
        pulses(8);
        chk("reflash_off", flash_exp(8));
        score = 7'd7;
        frame_start = 1'b1;
        @(negedge clock_25);
        frame_start = 1'b0;
        cyc(3);
        chk("event_vs_frame", flash_exp(0));
        pulses(7);
        chk("cnt_cleared", flash_exp(7));
        pulses(1);
        chk("cnt_wrap", flash_exp(8));
        sync_reset = 1'b1;
        score = '0;
        @(negedge clock_25);
        chk("sync_flash", 14'h0);
        sync_reset = 1'b0;
        cyc(3);
        chk("post_sync_idle", {2'b11, FG});
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
